execute_stage: RTL

- Second CPU pipeline stage (EX). Sits between fetchdecode and the MEM/WB stage.
- Consumes decoded operands and control from fetchdecode, resolves data hazards by forwarding, and computes the ALU result, memory/bus address and store data.
- Owns the NVZ flag register fed back to fetchdecode for branch evaluation.
- Runs an iterative multiplier that stalls the front end while it is busy.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/ex_mul.sv | 44 ++++
 rtl/execute_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, flag indices, multiplier states and datapath defaults
package cpu_pkg;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_RADDR_W = 4;
   localparam int NVZ_N = 2;
   localparam int NVZ_V = 1;
   localparam int NVZ_Z = 0;
   typedef enum logic [4:0] {
      OP_ADD = 5'b00000, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOOP, OP_MUL, OP_BRANCH,
      OP_IMML, OP_IMMH, OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBSTORE
   } opcode_e;
   typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_e;
endpackage

// File: rtl/ex_mul.sv
// ex_mul: iterative radix-2 shift-add multiplier, one step per clock, W steps
module ex_mul
   import cpu_pkg::*;
#(
   parameter int W = DEF_WIDTH
) (
   input  logic         iclk,
   input  logic         irst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] product
);
   localparam int CW = $clog2(W);
   mul_state_e state, state_n;
   logic [CW-1:0] cnt;
   logic [W-1:0] ar, br, acc, step;
   assign busy    = state == MUL_BUSY;
   assign done    = busy && cnt == CW'(W - 1);
   assign step    = br[0] ? ar : '0;
   assign product = acc + step;
   always_comb begin
      state_n = state;
      state_n = (state == MUL_IDLE && start) ? MUL_BUSY : done ? MUL_IDLE : state;
   end
   always_ff @(posedge iclk) begin
      state <= irst ? MUL_IDLE : state_n;
   end
   always_ff @(posedge iclk) begin
      if (state == MUL_IDLE && start) begin
         ar  <= a;
         br  <= b;
         acc <= '0;
         cnt <= '0;
      end else if (busy) begin
         acc <= product;
         ar  <= ar << 1;
         br  <= br >> 1;
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage with forwarding, ALU, NVZ flags; iterative MUL built only when EX_MUL_EN is defined
module execute_stage
   import cpu_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int RADDR_W = DEF_RADDR_W
) (
   input  logic               iclk,
   input  logic               irst,
   input  logic [WIDTH-1:0]   iData1,
   input  logic [WIDTH-1:0]   iData2,
   input  logic [WIDTH-1:0]   iImm,
   input  logic [4:0]         iOpcode,
   input  logic               iALUSrc,
   input  logic [RADDR_W-1:0] iSr1,
   input  logic [RADDR_W-1:0] iSr2,
   input  logic               iWriteReg,
   input  logic               iMemtoReg,
   input  logic               iBustoReg,
   input  logic               iMemRead,
   input  logic               iMemWrite,
   input  logic               iBusWrite,
   input  logic [RADDR_W-1:0] iWriteRegAddr,
   input  logic               iWbWrite,
   input  logic [RADDR_W-1:0] iWbAddr,
   input  logic [WIDTH-1:0]   iWbData,
   output logic [WIDTH-1:0]   oResult,
   output logic [WIDTH-1:0]   oStoreData,
   output logic               oWriteReg,
   output logic               oMemtoReg,
   output logic               oBustoReg,
   output logic               oMemRead,
   output logic               oMemWrite,
   output logic               oBusWrite,
   output logic [RADDR_W-1:0] oWriteRegAddr,
   output logic [2:0]         oNVZ,
   output logic               oStall
);
   logic [WIDTH-1:0] fa, fb, opb, sum, dif, res, mul_p;
   logic [RADDR_W-1:0] mul_dst;
   logic [5:0] ctl, mul_ctl;
   logic upd, v, bubble, mul_busy, mul_done, ex_fwd_ok;
   assign ex_fwd_ok = oWriteReg && !oMemtoReg && !oBustoReg;
   assign fa  = (ex_fwd_ok && iSr1 != '0 && oWriteRegAddr == iSr1) ? oResult :
                (iWbWrite && iSr1 != '0 && iWbAddr == iSr1) ? iWbData : iData1;
   assign fb  = (ex_fwd_ok && iSr2 != '0 && oWriteRegAddr == iSr2) ? oResult :
                (iWbWrite && iSr2 != '0 && iWbAddr == iSr2) ? iWbData : iData2;
   assign opb = iALUSrc ? iImm : fb;
   assign sum = fa + opb;
   assign dif = fa - opb;
   assign ctl = {iWriteReg, iMemtoReg, iBustoReg, iMemRead, iMemWrite, iBusWrite};
   always_comb begin
      res    = '0;
      upd    = 1'b0;
      v      = 1'b0;
      bubble = 1'b0;
      case (iOpcode)
         OP_ADD: begin
            res = sum;
            upd = 1'b1;
            v   = (fa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != fa[WIDTH-1]);
         end
         OP_SUB: begin
            res = dif;
            upd = 1'b1;
            v   = (fa[WIDTH-1] != opb[WIDTH-1]) && (dif[WIDTH-1] != fa[WIDTH-1]);
         end
         OP_AND: begin
            res = fa & opb;
            upd = 1'b1;
         end
         OP_OR: begin
            res = fa | opb;
            upd = 1'b1;
         end
         OP_XOR: begin
            res = fa ^ opb;
            upd = 1'b1;
         end
         OP_IMML: res = iImm;
         OP_IMMH: res = iImm | (fa & WIDTH'(16'h00FF));
         OP_LOAD, OP_STORE, OP_DBLOAD, OP_DBSTORE: res = fa;
         default: bubble = 1'b1;
      endcase
   end
`ifdef EX_MUL_EN
   logic mul_start;
   assign mul_start = iOpcode == OP_MUL && !mul_busy;
   assign oStall    = !irst && (mul_busy ? !mul_done : mul_start);
   ex_mul #(.W(WIDTH)) u_mul (
      .iclk    (iclk),
      .irst    (irst),
      .start   (mul_start),
      .a       (fa),
      .b       (opb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_p)
   );
   always_ff @(posedge iclk) begin
      if (mul_start) begin
         mul_ctl <= ctl;
         mul_dst <= iWriteRegAddr;
      end
   end
`else
   assign mul_busy = 1'b0;
   assign mul_done = 1'b0;
   assign mul_p    = '0;
   assign mul_ctl  = '0;
   assign mul_dst  = '0;
   assign oStall   = 1'b0;
`endif
   always_ff @(posedge iclk) begin
      if (irst) begin
         oResult <= '0;
         oStoreData <= '0;
         {oWriteReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite} <= '0;
         oWriteRegAddr <= '0;
         oNVZ <= '0;
      end else if (mul_done) begin
         oResult <= mul_p;
         {oWriteReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite} <= mul_ctl;
         oWriteRegAddr <= mul_dst;
         oNVZ[NVZ_N] <= mul_p[WIDTH-1];
         oNVZ[NVZ_V] <= 1'b0;
         oNVZ[NVZ_Z] <= mul_p == '0;
      end else if (mul_busy || bubble) begin
         {oWriteReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite} <= '0;
         oWriteRegAddr <= '0;
      end else begin
         oResult <= res;
         oStoreData <= fb;
         {oWriteReg, oMemtoReg, oBustoReg, oMemRead, oMemWrite, oBusWrite} <= ctl;
         oWriteRegAddr <= iWriteRegAddr;
         if (upd) begin
            oNVZ[NVZ_N] <= res[WIDTH-1];
            oNVZ[NVZ_V] <= v;
            oNVZ[NVZ_Z] <= res == '0;
         end
      end
   end
endmodule
